// File: rtl/aexm_dwb_pkg.sv
// Shared data-bus definitions: byte-lane select encodings, responder state encoding, lane helpers.
package aexm_dwb_pkg;

    localparam logic [3:0] SEL_B0  = 4'h8;
    localparam logic [3:0] SEL_B1  = 4'h4;
    localparam logic [3:0] SEL_B2  = 4'h2;
    localparam logic [3:0] SEL_B3  = 4'h1;
    localparam logic [3:0] SEL_H0  = 4'hC;
    localparam logic [3:0] SEL_H1  = 4'h3;
    localparam logic [3:0] SEL_W   = 4'hF;
    localparam logic [3:0] SEL_FSL = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } dspm_state_t;

    function automatic logic sel_legal(input logic [3:0] sel);
        case (sel)
            SEL_B0, SEL_B1, SEL_B2, SEL_B3, SEL_H0, SEL_H1, SEL_W: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // sel bit 3 selects the most significant (lowest-address) byte
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/aexm_dspm_if.sv
// Data-port bus between the core (master) and the scratchpad responder (slave).
interface aexm_dspm_if;
    logic        dwb_stb_i;
    logic        dwb_we_i;
    logic [3:0]  dwb_sel_i;
    logic [29:0] dwb_adr_i;
    logic [31:0] dwb_dat_i;
    logic        dwb_ack_o;
    logic        dwb_err_o;
    logic [31:0] dwb_dat_o;
    logic        dspm_busy;

    modport master (
        output dwb_stb_i, dwb_we_i, dwb_sel_i, dwb_adr_i, dwb_dat_i,
        input  dwb_ack_o, dwb_err_o, dwb_dat_o, dspm_busy
    );

    modport slave (
        input  dwb_stb_i, dwb_we_i, dwb_sel_i, dwb_adr_i, dwb_dat_i,
        output dwb_ack_o, dwb_err_o, dwb_dat_o, dspm_busy
    );
endinterface

// File: rtl/aexm_dspm_ram.sv
// Single-port synchronous RAM, 2^(AW-2) x 32, per-lane write enables, registered read (read-first).
module aexm_dspm_ram #(
    parameter int AW = 12
) (
    input  logic          gclk,
    input  logic [AW-3:0] addr,
    input  logic [3:0]    wen,
    input  logic [31:0]   wdat,
    output logic [31:0]   rdat
);
    localparam int DEPTH = 1 << (AW - 2);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge gclk) begin
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) mem[addr][8*b +: 8] <= wdat[8*b +: 8];
        end
        rdat <= mem[addr];
    end
endmodule

// File: rtl/aexm_dspm.sv
// Data-side scratchpad responder: lane-masked loads/stores with WAIT wait states, one-cycle ack or err.
module aexm_dspm
    import aexm_dwb_pkg::*;
#(
    parameter int          AW   = 12,
    parameter int          WAIT = 1,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic        gclk,
    input  logic        grst,
    aexm_dspm_if.slave  dwb
);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    dspm_state_t   state;
    logic [3:0]    cnt;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [AW-3:0] adr_q;
    logic [31:0]   dat_q;
    logic          ack;
    logic          err;
    logic          busy;

    logic          in_range;
    logic [AW-3:0] ram_addr;
    logic [3:0]    ram_wen;
    logic [31:0]   ram_rdat;

    assign in_range = (dwb.dwb_adr_i[29:AW-2] == BASE[31:AW]);

    // Address the RAM straight from the bus while idle so the read is already
    // registered when a zero-wait transfer reaches ACK.
    assign ram_addr = (state == ST_IDLE) ? dwb.dwb_adr_i[AW-3:0] : adr_q;
    assign ram_wen  = (state == ST_ACK && we_q && !grst) ? sel_q : 4'b0000;

    aexm_dspm_ram #(.AW(AW)) u_ram (
        .gclk (gclk),
        .addr (ram_addr),
        .wen  (ram_wen),
        .wdat (dat_q),
        .rdat (ram_rdat)
    );

    always_ff @(posedge gclk) begin
        if (grst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            ack   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dwb.dwb_stb_i) begin
                        we_q  <= dwb.dwb_we_i;
                        sel_q <= dwb.dwb_sel_i;
                        adr_q <= dwb.dwb_adr_i[AW-3:0];
                        dat_q <= dwb.dwb_dat_i;
                        busy  <= 1'b1;
                        if (!in_range || !sel_legal(dwb.dwb_sel_i)) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else if (WAIT == 0) begin
                            state <= ST_ACK;
                            ack   <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_CNT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_ACK;
                        ack   <= 1'b1;
                    end
                end
                ST_ACK, ST_ERR: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dwb.dwb_ack_o = ack;
    assign dwb.dwb_err_o = err;
    assign dwb.dspm_busy = busy;
    assign dwb.dwb_dat_o = (ack && !we_q) ? (ram_rdat & lane_mask(sel_q)) : 32'h0;

endmodule

// File: tb/tb_aexm_dspm.sv
// Bench for aexm_dspm: three instances (WAIT=1/0/3) checked against a lane-level memory model.
module tb_aexm_dspm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst;
    logic [2:0]       stb;
    logic [2:0]       we;
    logic [2:0][3:0]  sel;
    logic [2:0][29:0] adr;
    logic [2:0][31:0] wd;
    logic [2:0]       ack_w;
    logic [2:0]       err_w;
    logic [2:0]       busy_w;
    logic [2:0][31:0] dat_w;

    aexm_dspm_if if0 ();
    aexm_dspm_if if1 ();
    aexm_dspm_if if2 ();

    assign if0.dwb_stb_i = stb[0]; assign if0.dwb_we_i = we[0]; assign if0.dwb_sel_i = sel[0];
    assign if0.dwb_adr_i = adr[0]; assign if0.dwb_dat_i = wd[0];
    assign if1.dwb_stb_i = stb[1]; assign if1.dwb_we_i = we[1]; assign if1.dwb_sel_i = sel[1];
    assign if1.dwb_adr_i = adr[1]; assign if1.dwb_dat_i = wd[1];
    assign if2.dwb_stb_i = stb[2]; assign if2.dwb_we_i = we[2]; assign if2.dwb_sel_i = sel[2];
    assign if2.dwb_adr_i = adr[2]; assign if2.dwb_dat_i = wd[2];

    assign ack_w[0] = if0.dwb_ack_o; assign err_w[0] = if0.dwb_err_o;
    assign busy_w[0] = if0.dspm_busy; assign dat_w[0] = if0.dwb_dat_o;
    assign ack_w[1] = if1.dwb_ack_o; assign err_w[1] = if1.dwb_err_o;
    assign busy_w[1] = if1.dspm_busy; assign dat_w[1] = if1.dwb_dat_o;
    assign ack_w[2] = if2.dwb_ack_o; assign err_w[2] = if2.dwb_err_o;
    assign busy_w[2] = if2.dspm_busy; assign dat_w[2] = if2.dwb_dat_o;

    aexm_dspm #(.AW(12), .WAIT(1), .BASE(32'h0000_0000)) u0 (.gclk(clk), .grst(rst[0]), .dwb(if0.slave));
    aexm_dspm #(.AW(12), .WAIT(0), .BASE(32'h0000_0000)) u1 (.gclk(clk), .grst(rst[1]), .dwb(if1.slave));
    aexm_dspm #(.AW(12), .WAIT(3), .BASE(32'h0000_3000)) u2 (.gclk(clk), .grst(rst[2]), .dwb(if2.slave));

    int checks = 0;
    int errors = 0;

    logic [31:0] model [3][16];
    logic [3:0]  legal_tab [7] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF};

    function automatic int wait_of(input int k);
        if (k == 0) return 1;
        if (k == 1) return 0;
        return 3;
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 2) ? 32'h0000_3000 : 32'h0000_0000;
    endfunction

    function automatic bit sel_ok(input logic [3:0] s);
        for (int i = 0; i < 7; i++) if (legal_tab[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] bytes_of(input logic [3:0] s);
        logic [31:0] m = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request now; count rising edges until ack/err, checking dat_o stays 0 meanwhile.
    task automatic run_txn(input int k, input bit w, input logic [3:0] s, input logic [29:0] a,
                           input logic [31:0] d, input bit keep,
                           output int lat, output bit got_ack, output bit got_err, output logic [31:0] rd);
        stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; wd[k] = d;
        lat = -1; got_ack = 1'b0; got_err = 1'b0; rd = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (ack_w[k] || err_w[k]) begin
                lat = c; got_ack = ack_w[k]; got_err = err_w[k]; rd = dat_w[k];
                if (err_w[k]) chk("dat_on_err", dat_w[k], 32'h0);
                break;
            end
            chk("dat_idle", dat_w[k], 32'h0);
        end
        if (lat < 0) chk("timeout", 32'h0, 32'h1);
        if (!keep) stb[k] = 1'b0;
    endtask

    task automatic op(input int k, input bit w, input logic [3:0] s, input int idx, input logic [31:0] d,
                      input bit oor, input bit b2b, input bit keep);
        logic [29:0] a;
        bit          legal;
        int          exp_lat, lat;
        bit          ga, ge;
        logic [31:0] rd;
        a = 30'(base_of(k) >> 2) + 30'(idx) + (oor ? 30'h400 : 30'h0);
        legal = !oor && sel_ok(s);
        exp_lat = legal ? 1 + wait_of(k) : 1;
        if (b2b) exp_lat = exp_lat + 1;
        else begin
            @(posedge clk);
            @(negedge clk);
        end
        run_txn(k, w, s, a, d, keep, lat, ga, ge, rd);
        chk($sformatf("lat_k%0d", k), 32'(lat), 32'(exp_lat));
        chk($sformatf("ack_k%0d", k), {31'h0, ga}, {31'h0, legal});
        chk($sformatf("err_k%0d", k), {31'h0, ge}, {31'h0, !legal});
        if (legal && !w) chk($sformatf("rdat_k%0d_i%0d", k, idx), rd, model[k][idx] & bytes_of(s));
        if (legal && w)
            for (int b = 0; b < 4; b++) if (s[b]) model[k][idx][8*b +: 8] = d[8*b +: 8];
    endtask

    initial begin
        rst = 3'b111; stb = '0; we = '0; sel = '0; adr = '0; wd = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ack", {31'h0, ack_w[k]}, 32'h0);
            chk("rst_err", {31'h0, err_w[k]}, 32'h0);
            chk("rst_busy", {31'h0, busy_w[k]}, 32'h0);
            chk("rst_dat", dat_w[k], 32'h0);
        end
        rst = 3'b000;

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) op(k, 1'b1, 4'hF, i, $urandom, 1'b0, 1'b0, 1'b0);

        // Word store/load at byte address 0x10, then byte merge and half-lane load
        op(0, 1'b1, 4'hF, 4, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        op(0, 1'b0, 4'hF, 4, 32'h0, 1'b0, 1'b0, 1'b0);
        op(0, 1'b1, 4'hF, 6, 32'h11223344, 1'b0, 1'b0, 1'b0);
        op(0, 1'b1, 4'h4, 6, 32'h00AA0000, 1'b0, 1'b0, 1'b0);
        op(0, 1'b0, 4'hF, 6, 32'h0, 1'b0, 1'b0, 1'b0);
        op(0, 1'b0, 4'h2, 6, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("merge_model", model[0][6], 32'h11AA3344);

        // Illegal accesses leave memory untouched
        op(0, 1'b1, 4'hF, 6, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        op(0, 1'b1, 4'h0, 6, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        op(0, 1'b1, 4'h5, 6, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        op(0, 1'b0, 4'hF, 6, 32'h0, 1'b0, 1'b0, 1'b0);
        op(2, 1'b1, 4'hF, 3, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        op(2, 1'b0, 4'hF, 3, 32'h0, 1'b0, 1'b0, 1'b0);

        // Zero-wait back-to-back with strobe held through ack
        op(1, 1'b1, 4'hF, 2, 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b1);
        op(1, 1'b0, 4'hF, 2, 32'h0, 1'b0, 1'b1, 1'b1);
        op(1, 1'b0, 4'hC, 3, 32'h0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a store's wait states
        op(2, 1'b1, 4'hF, 5, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; adr[2] = 30'((32'h3000 >> 2) + 5); wd[2] = 32'h12345678;
        @(posedge clk);
        #1;
        chk("busy_in_wait", {31'h0, busy_w[2]}, 32'h1);
        @(posedge clk);
        #1;
        rst[2] = 1'b1; stb[2] = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_ack", {31'h0, ack_w[2]}, 32'h0);
        chk("mrst_err", {31'h0, err_w[2]}, 32'h0);
        chk("mrst_busy", {31'h0, busy_w[2]}, 32'h0);
        chk("mrst_dat", dat_w[2], 32'h0);
        rst[2] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_ack", {31'h0, ack_w[2]}, 32'h0);
        end
        op(2, 1'b0, 4'hF, 5, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_model", model[2][5], 32'hCAFEF00D);

        op(2, 1'b0, 4'hF, 1, 32'h0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            int          k;
            logic [3:0]  s;
            k = int'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) s = 4'($urandom_range(0, 15));
            else s = legal_tab[$urandom_range(0, 6)];
            op(k, 1'($urandom_range(0, 1)), s, int'($urandom_range(0, 15)), $urandom,
               ($urandom_range(0, 9) == 0), 1'b0, 1'b0);
        end

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) op(k, 1'b0, 4'hF, i, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aexm_dspm.md
Name: aexm_dspm

Overview:
- Data-side scratchpad responder: the memory end of the core's data port.
- Accepts word address, byte-lane select, write enable and store data from the execute/memory stages.
- Returns big-endian lane-masked read data, or commits lane-masked writes after a configurable number of wait states.
- Signals completion with a one-cycle ack and flags illegal accesses with a one-cycle err.

Parameters:
- AW, 12: byte-address width of scratchpad; depth = 2^(AW-2) 32-bit words.
- WAIT, 1: wait states between request acceptance and ack (0..15).
- BASE, 32'h0000_0000: base address; must be aligned to 2^AW.

Ports:
- gclk  in  1  clock
- grst  in  1  synchronous active-high reset
- dwb_stb_i  in  1  request strobe, held by master until ack/err
- dwb_we_i  in  1  1 = store, 0 = load
- dwb_sel_i  in  4  byte lanes; 8 = bits 31:24 (lowest address), 1 = bits 7:0
- dwb_adr_i  in  30  word address [31:2]
- dwb_dat_i  in  32  store data, lane-aligned
- dwb_ack_o  out  1  one-cycle completion pulse
- dwb_err_o  out  1  one-cycle error pulse (replaces ack)
- dwb_dat_o  out  32  load data, valid only while dwb_ack_o=1
- dspm_busy  out  1  high from acceptance until the cycle after ack/err

Behaviour:
- Clock and reset: one clock, gclk; synchronous active-high reset, grst.
- Reset values: dwb_ack_o=0, dwb_err_o=0, dwb_dat_o=0, dspm_busy=0, state=IDLE, wait counter=0. RAM contents are not reset.
- States: IDLE, WAIT, ACK, ERR.
- IDLE:
  - On dwb_stb_i=1, latch adr, we, sel and dat, then set busy.
  - The access is illegal if adr[31:AW] != BASE[31:AW], or if sel is not one of {8,4,2,1,C,3,F}. Sel 0 is the FSL encoding and is illegal. An illegal access goes to ERR.
  - Otherwise go to WAIT with counter=WAIT; if WAIT=0, go directly to ACK.
- WAIT: decrement the counter each cycle; move to ACK on the cycle the counter reaches 1.
- ACK:
  - dwb_ack_o=1 for exactly one cycle.
  - Load: dwb_dat_o = RAM word with unselected lanes forced to 0.
  - Store: selected lanes are written on the ACK clock edge; unselected lanes are unchanged.
  - Next state is IDLE.
- ERR: dwb_err_o=1 for one cycle, no RAM write, dwb_dat_o=0; next state is IDLE.
- Latency: request in cycle N gives ack in cycle N+1+WAIT.
- RAM read: the RAM read is issued one cycle before ACK (synchronous RAM), so WAIT=0 still yields the correct data.
- Strobe in ACK/ERR cycle: dwb_stb_i=1 in the ACK or ERR cycle is the tail of the current transfer and is ignored. Minimum spacing between accepted requests is one IDLE cycle.
- Strobe dropped early: if dwb_stb_i drops during WAIT, the transfer still completes (ack issued, store committed). The master must not do this.
- Input stability: inputs are sampled only at acceptance; later changes during WAIT have no effect.
- Read-after-write: a load accepted after a store's ack returns the new data.
- Reset mid-transfer: abort immediately; no write occurs, no ack/err, state=IDLE next cycle.
- Address wrap: the index is adr[AW-1:2] only; in-range addresses never wrap.

Decomposition:
- Shared package aexm_dwb_pkg holds:
  - sel encodings: SEL_B0..B3 = 8/4/2/1, SEL_H0 = C, SEL_H1 = 3, SEL_W = F, SEL_FSL = 0.
  - state encoding.
  - a legal-sel function.
- Sub-module aexm_dspm_ram: single-port synchronous RAM, 2^(AW-2)x32, per-lane write enables, registered read.

Test Plan:
1. WAIT=1: store adr 0x10, sel F, dat 0xDEADBEEF; then load adr 0x10, sel F -> each ack 2 cycles after stb; load returns 0xDEADBEEF.
2. Byte store sel 4, dat 0x00AA0000 to the word holding 0x11223344; load sel F -> 0x11AA3344. Load sel 2 -> 0x00003300.
3. Out-of-range adr (BASE+0x1000 with AW=12), and sel 0 -> err pulse 1 cycle, no ack, RAM unchanged.
4. WAIT=0, back-to-back requests with stb held high through ack -> second request accepted only after one IDLE cycle; both acks correct.
5. grst asserted during WAIT of a store 0x12345678 -> no ack, outputs zero next cycle; a later load returns the old value.
6. WAIT=3 load -> ack exactly 4 cycles after acceptance; dwb_dat_o=0 in all non-ack cycles.
